// File: rtl/hazard_ctrl_if.sv
// ============================================================================
//  hazard_ctrl_if : pipeline hazard sideband bundle between datapath and
//                   hazard_ctrl.  Rev 1.0
// ============================================================================
`default_nettype none

interface hazard_ctrl_if;
  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic        use_rs_id;
  logic        use_rt_id;
  logic        branch_id;
  logic        md_use_id;
  logic        RegWrite_ex;
  logic        RegWrite_mem;
  logic [1:0]  MemtoReg_ex;
  logic [1:0]  MemtoReg_mem;
  logic [4:0]  wa_ex;
  logic [4:0]  wa_mem;
  logic [1:0]  md_start_ex;
  logic        stall;
  logic        bubble_ex;
  logic        md_busy;
  logic [3:0]  md_cnt;
  logic [15:0] stall_cnt;

  modport master (
    output rs_id, rt_id, use_rs_id, use_rt_id, branch_id, md_use_id,
           RegWrite_ex, RegWrite_mem, MemtoReg_ex, MemtoReg_mem,
           wa_ex, wa_mem, md_start_ex,
    input  stall, bubble_ex, md_busy, md_cnt, stall_cnt
  );

  modport slave (
    input  rs_id, rt_id, use_rs_id, use_rt_id, branch_id, md_use_id,
           RegWrite_ex, RegWrite_mem, MemtoReg_ex, MemtoReg_mem,
           wa_ex, wa_mem, md_start_ex,
    output stall, bubble_ex, md_busy, md_cnt, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  hazard_ctrl : load-use / branch-operand / MDU-busy stall generation with
//                saturating stall counter.  Rev 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl (
  input  wire logic    clk,
  input  wire logic    reset,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} md_state_e;

  localparam logic [3:0] c_MULT_CYC = 4'd5;
  localparam logic [3:0] c_DIV_CYC  = 4'd10;
  localparam logic [1:0] c_LOAD     = 2'b01;

  md_state_e   state_q = IDLE;
  md_state_e   state_d;
  logic [3:0]  md_cnt_q = '0;
  logic [3:0]  md_cnt_d;
  logic [15:0] stall_cnt_q = '0;
  logic [15:0] stall_cnt_d;

  logic w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
  logic w_ex_wr, w_mem_ld;
  logic w_ld_hit, w_br_hit, w_md_hit;
  logic w_mult, w_div, w_stall;

  assign w_rs_ex  = bus.use_rs_id && (bus.rs_id == bus.wa_ex);
  assign w_rt_ex  = bus.use_rt_id && (bus.rt_id == bus.wa_ex);
  assign w_rs_mem = bus.use_rs_id && (bus.rs_id == bus.wa_mem);
  assign w_rt_mem = bus.use_rt_id && (bus.rt_id == bus.wa_mem);

  assign w_ex_wr  = bus.RegWrite_ex && (bus.wa_ex != 5'd0);
  assign w_mem_ld = bus.RegWrite_mem && (bus.MemtoReg_mem == c_LOAD) && (bus.wa_mem != 5'd0);

  // Encoding 11 is reserved and behaves exactly like "no MDU op".
  assign w_mult = (bus.md_start_ex == 2'b01);
  assign w_div  = (bus.md_start_ex == 2'b10);

  assign w_ld_hit = w_ex_wr && (bus.MemtoReg_ex == c_LOAD) && (w_rs_ex || w_rt_ex);
  assign w_br_hit = bus.branch_id &&
                    ((w_ex_wr && (w_rs_ex || w_rt_ex)) || (w_mem_ld && (w_rs_mem || w_rt_mem)));
  assign w_md_hit = bus.md_use_id && ((state_q == BUSY) || w_mult || w_div);

  assign w_stall = !reset && (w_ld_hit || w_br_hit || w_md_hit);

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    if (w_mult) begin
      state_d  = BUSY;
      md_cnt_d = c_MULT_CYC;
    end else if (w_div) begin
      state_d  = BUSY;
      md_cnt_d = c_DIV_CYC;
    end else if (state_q == BUSY) begin
      if (md_cnt_q <= 4'd1) begin
        state_d  = IDLE;
        md_cnt_d = 4'd0;
      end else begin
        md_cnt_d = md_cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall     = w_stall;
  assign bus.bubble_ex = reset || w_stall;
  assign bus.md_busy   = (state_q == BUSY);
  assign bus.md_cnt    = md_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  tb_hazard_ctrl : directed scoreboard bench for hazard_ctrl.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic clk;
  logic reset;

  hazard_ctrl_if bus ();

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] sc_model = 16'd0;

  task automatic push_exp(input string t, input logic [15:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic cmp(input logic [15:0] obs);
    exp_t e;
    e = sb.pop_front();
    tests++;
    assert (obs === e.val) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  task automatic idle_inputs();
    bus.rs_id        = 5'd0;
    bus.rt_id        = 5'd0;
    bus.use_rs_id    = 1'b0;
    bus.use_rt_id    = 1'b0;
    bus.branch_id    = 1'b0;
    bus.md_use_id    = 1'b0;
    bus.RegWrite_ex  = 1'b0;
    bus.RegWrite_mem = 1'b0;
    bus.MemtoReg_ex  = 2'b00;
    bus.MemtoReg_mem = 2'b00;
    bus.wa_ex        = 5'd0;
    bus.wa_mem       = 5'd0;
    bus.md_start_ex  = 2'b00;
  endtask

  // Model step: queue expectations for the current inputs, check at negedge,
  // then cross one rising edge and advance the stall-counter model.
  task automatic cyc(input string name, input logic s, input logic b,
                     input logic busy, input logic [3:0] cnt);
    push_exp({name, ".stall"},     {15'd0, s});
    push_exp({name, ".bubble_ex"}, {15'd0, b});
    push_exp({name, ".md_busy"},   {15'd0, busy});
    push_exp({name, ".md_cnt"},    {12'd0, cnt});
    push_exp({name, ".stall_cnt"}, sc_model);
    @(negedge clk);
    cmp({15'd0, bus.stall});
    cmp({15'd0, bus.bubble_ex});
    cmp({15'd0, bus.md_busy});
    cmp({12'd0, bus.md_cnt});
    cmp(bus.stall_cnt);
    @(posedge clk);
    if (reset) sc_model = 16'd0;
    else if (s && sc_model != 16'hFFFF) sc_model = sc_model + 16'd1;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    cyc("reset0", 1'b0, 1'b1, 1'b0, 4'd0);
    cyc("reset1", 1'b0, 1'b1, 1'b0, 4'd0);
    reset = 1'b0;
    cyc("idle", 1'b0, 1'b0, 1'b0, 4'd0);

    // load-use on rs
    bus.RegWrite_ex = 1'b1; bus.MemtoReg_ex = 2'b01; bus.wa_ex = 5'd8;
    bus.use_rs_id = 1'b1; bus.rs_id = 5'd8;
    cyc("ld_use", 1'b1, 1'b1, 1'b0, 4'd0);
    bus.wa_ex = 5'd0; bus.rs_id = 5'd0;
    cyc("ld_zero", 1'b0, 1'b0, 1'b0, 4'd0);
    bus.wa_ex = 5'd8; bus.use_rs_id = 1'b0; bus.rt_id = 5'd8;
    cyc("ld_rt_unused", 1'b0, 1'b0, 1'b0, 4'd0);
    bus.use_rt_id = 1'b1;
    cyc("ld_rt", 1'b1, 1'b1, 1'b0, 4'd0);

    // branch after ALU op in EX, then released
    idle_inputs();
    bus.branch_id = 1'b1; bus.rt_id = 5'd9; bus.use_rt_id = 1'b1;
    bus.RegWrite_ex = 1'b1; bus.wa_ex = 5'd9;
    cyc("br_alu", 1'b1, 1'b1, 1'b0, 4'd0);
    bus.RegWrite_ex = 1'b0;
    cyc("br_alu_rel", 1'b0, 1'b0, 1'b0, 4'd0);
    bus.branch_id = 1'b0; bus.RegWrite_ex = 1'b1;
    cyc("alu_nobr", 1'b0, 1'b0, 1'b0, 4'd0);

    // branch after load in MEM
    idle_inputs();
    bus.branch_id = 1'b1; bus.rt_id = 5'd9; bus.use_rt_id = 1'b1;
    bus.RegWrite_mem = 1'b1; bus.MemtoReg_mem = 2'b01; bus.wa_mem = 5'd9;
    cyc("br_memld", 1'b1, 1'b1, 1'b0, 4'd0);
    bus.MemtoReg_mem = 2'b00;
    cyc("br_memalu", 1'b0, 1'b0, 1'b0, 4'd0);

    // all sources at once: still one stall per cycle
    bus.MemtoReg_mem = 2'b01;
    bus.RegWrite_ex = 1'b1; bus.MemtoReg_ex = 2'b01; bus.wa_ex = 5'd9;
    bus.md_use_id = 1'b1; bus.md_start_ex = 2'b01;
    cyc("multi_hit", 1'b1, 1'b1, 1'b0, 4'd0);
    reset = 1'b1;
    idle_inputs();
    cyc("clr", 1'b0, 1'b1, 1'b1, 4'd5);
    reset = 1'b0;
    cyc("clr_done", 1'b0, 1'b0, 1'b0, 4'd0);

    // div then mfhi
    bus.md_use_id = 1'b1; bus.md_start_ex = 2'b10;
    cyc("div_start", 1'b1, 1'b1, 1'b0, 4'd0);
    bus.md_start_ex = 2'b00;
    for (int k = 10; k >= 1; k--) cyc("div_busy", 1'b1, 1'b1, 1'b1, 4'(k));
    cyc("div_done", 1'b0, 1'b0, 1'b0, 4'd0);

    // reserved encoding does not start the MDU
    bus.md_use_id = 1'b0; bus.md_start_ex = 2'b11;
    cyc("md_rsvd", 1'b0, 1'b0, 1'b0, 4'd0);
    bus.md_start_ex = 2'b00;
    cyc("md_rsvd_idle", 1'b0, 1'b0, 1'b0, 4'd0);

    // mult, restart as div while busy, restart as mult, reset mid-op
    bus.md_start_ex = 2'b01;
    cyc("mult_start", 1'b0, 1'b0, 1'b0, 4'd0);
    bus.md_start_ex = 2'b00;
    cyc("mult5", 1'b0, 1'b0, 1'b1, 4'd5);
    bus.md_start_ex = 2'b10;
    cyc("restart_div", 1'b0, 1'b0, 1'b1, 4'd4);
    bus.md_start_ex = 2'b01;
    cyc("restart_mult", 1'b0, 1'b0, 1'b1, 4'd10);
    bus.md_start_ex = 2'b00;
    cyc("mult_r5", 1'b0, 1'b0, 1'b1, 4'd5);
    cyc("mult_r4", 1'b0, 1'b0, 1'b1, 4'd4);
    reset = 1'b1; bus.md_use_id = 1'b1;
    cyc("rst_mid", 1'b0, 1'b1, 1'b1, 4'd3);
    cyc("rst_held", 1'b0, 1'b1, 1'b0, 4'd0);
    reset = 1'b0;
    cyc("post_rst", 1'b0, 1'b0, 1'b0, 4'd0);

    // saturation of the stall counter
    idle_inputs();
    bus.RegWrite_ex = 1'b1; bus.MemtoReg_ex = 2'b01; bus.wa_ex = 5'd8;
    bus.use_rs_id = 1'b1; bus.rs_id = 5'd8;
    repeat (65537) begin
      @(posedge clk);
      if (sc_model != 16'hFFFF) sc_model = sc_model + 16'd1;
    end
    #1;
    cyc("sat0", 1'b1, 1'b1, 1'b0, 4'd0);
    cyc("sat1", 1'b1, 1'b1, 1'b0, 4'd0);
    idle_inputs();
    cyc("sat_idle", 1'b0, 1'b0, 1'b0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
